// File: rtl/code_lock_pkg.sv
// ============================================================================
// Module   : code_lock_pkg
// Purpose  : Shared state encodings, digit limit and timer sizing helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package code_lock_pkg;

    localparam logic [2:0] ST_WAIT   = 3'd0;
    localparam logic [2:0] ST_INPUT  = 3'd1;
    localparam logic [2:0] ST_UNLOCK = 3'd2;
    localparam logic [2:0] ST_ERROR  = 3'd3;
    localparam logic [2:0] ST_ALARM  = 3'd4;
    localparam logic [2:0] ST_ADMIN  = 3'd5;

    localparam int MAX_DIGIT = 9;

    // One spare bit above the largest duration keeps the compare free of wrap.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/code_entry_buf.sv
// ============================================================================
// Module   : code_entry_buf
// Purpose  : Digit entry shift register with count, push/backspace/clear.
// Revision : 1.0
// ============================================================================
`default_nettype none

module code_entry_buf
    import code_lock_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        push,
    input  logic [DIGIT_W-1:0]          push_val,
    input  logic                        pop,
    input  logic                        clear,
    output logic                        digit_ok,
    output logic [DIGITS*DIGIT_W-1:0]   code_buf,
    output logic [3:0]                  digit_cnt
);

    localparam int BUF_W = DIGITS * DIGIT_W;

    logic [BUF_W-1:0] r_code_buf;
    logic [3:0]       r_digit_cnt;

    // A digit is usable only if it is BCD and there is room left for it.
    assign digit_ok  = (32'(push_val) <= MAX_DIGIT) && (r_digit_cnt < 4'(DIGITS));
    assign code_buf  = r_code_buf;
    assign digit_cnt = r_digit_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_code_buf  <= '0;
            r_digit_cnt <= '0;
        end else if (clear) begin
            r_code_buf  <= '0;
            r_digit_cnt <= '0;
        end else if (pop) begin
            if (r_digit_cnt != 4'd0) begin
                r_code_buf  <= r_code_buf >> DIGIT_W;
                r_digit_cnt <= r_digit_cnt - 4'd1;
            end
        end else if (push && digit_ok) begin
            r_code_buf  <= (r_code_buf << DIGIT_W) | BUF_W'(push_val);
            r_digit_cnt <= r_digit_cnt + 4'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/code_lock_ctrl.sv
// ============================================================================
// Module   : code_lock_ctrl
// Purpose  : Password lock FSM: entry, compare, error/alarm, unlock, key change.
//            Macro CODE_LOCK_ALARM_TIMEOUT_EN: ALARM self-clears after ALARM_CYC.
// Revision : 1.0
// ============================================================================
`default_nettype none

module code_lock_ctrl
    import code_lock_pkg::*;
#(
    parameter int                         DIGITS       = 4,
    parameter int                         DIGIT_W      = 4,
    parameter int                         MAX_ERR      = 3,
    parameter int                         ERR_HOLD_CYC = 1000,
    parameter int                         UNLOCK_CYC   = 5000,
    parameter int                         ALARM_CYC    = 20000,
    parameter logic [DIGITS*DIGIT_W-1:0]  DEFAULT_KEY  = 16'h1234
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        digit_valid,
    input  logic [DIGIT_W-1:0]          digit_val,
    input  logic                        btn_ok,
    input  logic                        btn_back,
    input  logic                        btn_admin,
    output logic [2:0]                  state,
    output logic                        unlocked,
    output logic                        alarm,
    output logic [3:0]                  err_cnt,
    output logic [3:0]                  digit_cnt,
    output logic [DIGITS*DIGIT_W-1:0]   code_buf
);

    localparam int TMR_W = timer_width(ERR_HOLD_CYC, UNLOCK_CYC, ALARM_CYC);
    localparam logic [TMR_W-1:0] c_err_last    = TMR_W'(ERR_HOLD_CYC - 1);
    localparam logic [TMR_W-1:0] c_unlock_last = TMR_W'(UNLOCK_CYC - 1);
`ifdef CODE_LOCK_ALARM_TIMEOUT_EN
    localparam logic [TMR_W-1:0] c_alarm_last  = TMR_W'(ALARM_CYC - 1);
`endif
    localparam logic [3:0]       c_max_err     = 4'(MAX_ERR);

    logic [2:0]                 r_state;
    logic [3:0]                 r_err_cnt;
    logic [TMR_W-1:0]           r_timer;
    logic [DIGITS*DIGIT_W-1:0]  r_key;
    logic                       r_unlocked;
    logic                       r_alarm;

    logic [2:0]  w_next;
    logic [3:0]  w_err_next;
    logic [3:0]  w_err_inc;
    logic        w_key_load;
    logic        w_push;
    logic        w_pop;
    logic        w_clear;
    logic        w_tmr_run;
    logic        w_digit_ok;
    logic        w_full;
    logic        w_match;
    logic        w_ev_admin;
    logic        w_ev_ok;
    logic        w_ev_back;
    logic        w_ev_digit;

    // Only the highest-priority event of a cycle is ever acted upon.
    assign w_ev_admin = btn_admin;
    assign w_ev_ok    = btn_ok & ~btn_admin;
    assign w_ev_back  = btn_back & ~btn_ok & ~btn_admin;
    assign w_ev_digit = digit_valid & ~btn_back & ~btn_ok & ~btn_admin;

    assign w_full    = (digit_cnt == 4'(DIGITS));
    assign w_match   = (code_buf == r_key);
    assign w_err_inc = (r_err_cnt >= c_max_err) ? c_max_err : r_err_cnt + 4'd1;

    code_entry_buf #(
        .DIGITS  (DIGITS),
        .DIGIT_W (DIGIT_W)
    ) u_entry (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (w_push),
        .push_val  (digit_val),
        .pop       (w_pop),
        .clear     (w_clear),
        .digit_ok  (w_digit_ok),
        .code_buf  (code_buf),
        .digit_cnt (digit_cnt)
    );

    always_comb begin
        w_next     = r_state;
        w_err_next = r_err_cnt;
        w_key_load = 1'b0;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_clear    = 1'b0;
        w_tmr_run  = 1'b0;
        case (r_state)
            ST_WAIT: begin
                w_push = w_ev_digit;
                if (w_ev_digit && w_digit_ok) w_next = ST_INPUT;
            end
            ST_INPUT: begin
                if (w_ev_ok) begin
                    w_clear = 1'b1;
                    if (w_full && w_match) begin
                        w_next     = ST_UNLOCK;
                        w_err_next = 4'd0;
                    end else begin
                        w_err_next = w_err_inc;
                        w_next     = (w_err_inc == c_max_err) ? ST_ALARM : ST_ERROR;
                    end
                end else if (w_ev_back) begin
                    w_pop = 1'b1;
                    if (digit_cnt == 4'd1) w_next = ST_WAIT;
                end else begin
                    w_push = w_ev_digit;
                end
            end
            ST_UNLOCK: begin
                if (w_ev_admin)                   w_next = ST_ADMIN;
                else if (r_timer == c_unlock_last) w_next = ST_WAIT;
                else                              w_tmr_run = 1'b1;
            end
            ST_ERROR: begin
                if (r_timer == c_err_last) w_next = ST_WAIT;
                else                       w_tmr_run = 1'b1;
            end
            ST_ALARM: begin
`ifdef CODE_LOCK_ALARM_TIMEOUT_EN
                if (r_timer == c_alarm_last) begin
                    w_next     = ST_WAIT;
                    w_err_next = 4'd0;
                end else begin
                    w_tmr_run = 1'b1;
                end
`endif
            end
            ST_ADMIN: begin
                if (w_ev_admin) begin
                    w_clear = 1'b1;
                    w_next  = ST_WAIT;
                end else if (w_ev_ok) begin
                    if (w_full) begin
                        w_key_load = 1'b1;
                        w_clear    = 1'b1;
                        w_next     = ST_WAIT;
                    end
                end else if (w_ev_back) begin
                    w_pop = 1'b1;
                end else begin
                    w_push = w_ev_digit;
                end
            end
            default: w_next = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_WAIT;
            r_err_cnt  <= 4'd0;
            r_timer    <= '0;
            r_key      <= DEFAULT_KEY;
            r_unlocked <= 1'b0;
            r_alarm    <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_err_cnt  <= w_err_next;
            r_unlocked <= (w_next == ST_UNLOCK) || (w_next == ST_ADMIN);
            r_alarm    <= (w_next == ST_ALARM);
            if (w_key_load) r_key <= code_buf;
            if (w_next != r_state) r_timer <= '0;
            else if (w_tmr_run)    r_timer <= r_timer + 1'b1;
        end
    end

    assign state    = r_state;
    assign unlocked = r_unlocked;
    assign alarm    = r_alarm;
    assign err_cnt  = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_code_lock_ctrl.sv
// ============================================================================
// Module   : tb_code_lock_ctrl
// Purpose  : Self-checking bench: vector table, directed sequences, random run.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_code_lock_ctrl;

    localparam int DIGITS     = 4;
    localparam int DIGIT_W    = 4;
    localparam int MAX_ERR    = 3;
    localparam int ERR_HOLD   = 1000;
    localparam int UNLOCK_CYC = 5000;
    localparam int ALARM_CYC  = 20000;

    logic        clk;
    logic        reset_n;
    logic        digit_valid;
    logic [3:0]  digit_val;
    logic        btn_ok;
    logic        btn_back;
    logic        btn_admin;
    logic [2:0]  state;
    logic        unlocked;
    logic        alarm;
    logic [3:0]  err_cnt;
    logic [3:0]  digit_cnt;
    logic [15:0] code_buf;

    int checks;
    int errors;

    code_lock_ctrl #(
        .DIGITS       (DIGITS),
        .DIGIT_W      (DIGIT_W),
        .MAX_ERR      (MAX_ERR),
        .ERR_HOLD_CYC (ERR_HOLD),
        .UNLOCK_CYC   (UNLOCK_CYC),
        .ALARM_CYC    (ALARM_CYC),
        .DEFAULT_KEY  (16'h1234)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .digit_valid (digit_valid),
        .digit_val   (digit_val),
        .btn_ok      (btn_ok),
        .btn_back    (btn_back),
        .btn_admin   (btn_admin),
        .state       (state),
        .unlocked    (unlocked),
        .alarm       (alarm),
        .err_cnt     (err_cnt),
        .digit_cnt   (digit_cnt),
        .code_buf    (code_buf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: entry kept as a queue of digits, timer as a countdown.
    int m_state;
    int m_q[$];
    int m_key[$];
    int m_err;
    int m_rem;

    function automatic void m_go(input int s);
        m_state = s;
        case (s)
            2:       m_rem = UNLOCK_CYC;
            3:       m_rem = ERR_HOLD;
            4:       m_rem = ALARM_CYC;
            default: m_rem = 0;
        endcase
    endfunction

    function automatic void m_reset();
        m_q.delete();
        m_key = '{1, 2, 3, 4};
        m_err = 0;
        m_go(0);
    endfunction

    function automatic void m_step(input bit dv, input int dval, input bit ok,
                                   input bit back, input bit adm);
        int ev;
        bit acc;
        bit hit;
        ev  = adm ? 4 : ok ? 3 : back ? 2 : dv ? 1 : 0;
        acc = (ev == 1) && (dval <= 9) && (m_q.size() < DIGITS);
        case (m_state)
            0: if (acc) begin m_q.push_back(dval); m_go(1); end
            1: begin
                if (ev == 3) begin
                    hit = (m_q.size() == DIGITS);
                    if (hit) for (int i = 0; i < DIGITS; i++) if (m_q[i] != m_key[i]) hit = 0;
                    m_q.delete();
                    if (hit) begin
                        m_err = 0;
                        m_go(2);
                    end else begin
                        if (m_err < MAX_ERR) m_err++;
                        m_go((m_err == MAX_ERR) ? 4 : 3);
                    end
                end else if (ev == 2) begin
                    void'(m_q.pop_back());
                    if (m_q.size() == 0) m_go(0);
                end else if (acc) begin
                    m_q.push_back(dval);
                end
            end
            2: begin
                if (ev == 4) m_go(5);
                else begin
                    m_rem--;
                    if (m_rem == 0) m_go(0);
                end
            end
            3: begin
                m_rem--;
                if (m_rem == 0) m_go(0);
            end
            4: begin
`ifdef CODE_LOCK_ALARM_TIMEOUT_EN
                m_rem--;
                if (m_rem == 0) begin
                    m_err = 0;
                    m_go(0);
                end
`endif
            end
            5: begin
                if (ev == 4) begin
                    m_q.delete();
                    m_go(0);
                end else if (ev == 3) begin
                    if (m_q.size() == DIGITS) begin
                        m_key = m_q;
                        m_q.delete();
                        m_go(0);
                    end
                end else if (ev == 2) begin
                    if (m_q.size() > 0) void'(m_q.pop_back());
                end else if (acc) begin
                    m_q.push_back(dval);
                end
            end
            default: m_go(0);
        endcase
    endfunction

    function automatic logic [31:0] m_outputs();
        logic [15:0] b;
        logic        u;
        b = '0;
        foreach (m_q[i]) b = (b << 4) | 16'(m_q[i]);
        u = (m_state == 2) || (m_state == 5);
        return {3'b0, 3'(m_state), u, (m_state == 4), 4'(m_err), 4'(m_q.size()), b};
    endfunction

    function automatic logic [31:0] dut_outputs();
        return {3'b0, state, unlocked, alarm, err_cnt, digit_cnt, code_buf};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit dv, input logic [3:0] dval, input bit ok,
                         input bit back, input bit adm);
        digit_valid = dv;
        digit_val   = dval;
        btn_ok      = ok;
        btn_back    = back;
        btn_admin   = adm;
        @(posedge clk);
        m_step(dv, int'(dval), ok, back, adm);
        #1;
        chk("model", dut_outputs(), m_outputs());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 4'd0, 0, 0, 0);
    endtask

    task automatic digit(input logic [3:0] d);
        cycle(1, d, 0, 0, 0);
    endtask

    task automatic press_ok();
        cycle(0, 4'd0, 1, 0, 0);
    endtask

    task automatic press_admin();
        cycle(0, 4'd0, 0, 0, 1);
    endtask

    task automatic enter_code(input logic [15:0] code);
        for (int i = 3; i >= 0; i--) digit(code[i*4 +: 4]);
    endtask

    task automatic do_reset();
        digit_valid = 0;
        btn_ok      = 0;
        btn_back    = 0;
        btn_admin   = 0;
        digit_val   = 0;
        reset_n     = 0;
        m_reset();
        #2;
        chk("reset_async", dut_outputs(), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1;
    endtask

    typedef struct {
        bit         dv;
        logic [3:0] dval;
        bit         ok;
        bit         back;
        bit         adm;
        logic [2:0] st;
        logic [3:0] cnt;
        logic [15:0] cbuf;
    } vec_t;

    vec_t tbl[9];
    int   r;

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1;
        digit_valid = 0; digit_val = 0; btn_ok = 0; btn_back = 0; btn_admin = 0;
        #3;
        do_reset();

        // Entry with backspace, overflow and invalid digit, then OK beating BACK
        tbl[0] = '{1, 4'd1, 0, 0, 0, 3'd1, 4'd1, 16'h0001};
        tbl[1] = '{1, 4'd2, 0, 0, 0, 3'd1, 4'd2, 16'h0012};
        tbl[2] = '{1, 4'd9, 0, 0, 0, 3'd1, 4'd3, 16'h0129};
        tbl[3] = '{0, 4'd0, 0, 1, 0, 3'd1, 4'd2, 16'h0012};
        tbl[4] = '{1, 4'd3, 0, 0, 0, 3'd1, 4'd3, 16'h0123};
        tbl[5] = '{1, 4'd4, 0, 0, 0, 3'd1, 4'd4, 16'h1234};
        tbl[6] = '{1, 4'd7, 0, 0, 0, 3'd1, 4'd4, 16'h1234};
        tbl[7] = '{1, 4'hA, 0, 0, 0, 3'd1, 4'd4, 16'h1234};
        tbl[8] = '{0, 4'd0, 1, 1, 0, 3'd2, 4'd0, 16'h0000};
        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].dv, tbl[i].dval, tbl[i].ok, tbl[i].back, tbl[i].adm);
            chk($sformatf("tbl%0d", i), {9'b0, state, digit_cnt, code_buf},
                {9'b0, tbl[i].st, tbl[i].cnt, tbl[i].cbuf});
        end
        chk("unlock_flags", {unlocked, alarm, err_cnt}, {1'b1, 1'b0, 4'd0});
        idle(UNLOCK_CYC - 1);
        chk("unlock_hold", {state, unlocked}, {3'd2, 1'b1});
        idle(1);
        chk("unlock_end", {state, unlocked, err_cnt}, {3'd0, 1'b0, 4'd0});

        for (int k = 1; k <= 3; k++) begin
            enter_code(16'h1235);
            press_ok();
            if (k < 3) begin
                chk("err_enter", {state, err_cnt}, {3'd3, 4'(k)});
                idle(ERR_HOLD - 1);
                chk("err_hold", state, 3'd3);
                idle(1);
                chk("err_exit", state, 3'd0);
            end else begin
                chk("alarm_enter", {state, alarm, err_cnt}, {3'd4, 1'b1, 4'd3});
            end
        end
`ifdef CODE_LOCK_ALARM_TIMEOUT_EN
        idle(ALARM_CYC - 1);
        chk("alarm_hold", {state, alarm}, {3'd4, 1'b1});
        idle(1);
        chk("alarm_timeout", {state, alarm, err_cnt}, {3'd0, 1'b0, 4'd0});
`else
        enter_code(16'h1234);
        press_ok();
        idle(3000);
        chk("alarm_latched", {state, alarm, err_cnt}, {3'd4, 1'b1, 4'd3});
        do_reset();
`endif

        // Key change, old key rejected, new key accepted, aborted change
        enter_code(16'h1234); press_ok();
        press_admin();
        chk("admin_enter", {state, unlocked}, {3'd5, 1'b1});
        enter_code(16'h9876); press_ok();
        chk("admin_commit", {state, unlocked, digit_cnt}, {3'd0, 1'b0, 4'd0});
        enter_code(16'h1234); press_ok();
        chk("old_key", {state, err_cnt}, {3'd3, 4'd1});
        idle(ERR_HOLD);
        enter_code(16'h9876); press_ok();
        chk("new_key", {state, err_cnt}, {3'd2, 4'd0});
        press_admin();
        digit(4'd1); digit(4'd2); press_ok();
        chk("admin_short_ok", {state, digit_cnt}, {3'd5, 4'd2});
        cycle(0, 4'd0, 0, 1, 0);
        chk("admin_back", {state, digit_cnt, code_buf}, {3'd5, 4'd1, 16'h0001});
        press_admin();
        chk("admin_abort", {state, unlocked, digit_cnt}, {3'd0, 1'b0, 4'd0});
        enter_code(16'h9876); press_ok();
        chk("key_kept", state, 3'd2);
        press_admin();
        enter_code(16'h5555); press_ok();
        do_reset();
        enter_code(16'h1234); press_ok();
        chk("key_default_after_reset", state, 3'd2);
        idle(UNLOCK_CYC);

        enter_code(16'h0123); press_ok();
        digit(4'd1); digit(4'd2); digit(4'd3); press_ok();
        chk("short_entry", {state, err_cnt}, {3'd3, 4'd1});
        idle(ERR_HOLD);
        digit(4'd3);
        chk("single_digit", {state, digit_cnt}, {3'd1, 4'd1});
        cycle(0, 4'd0, 0, 1, 0);
        chk("back_to_wait", {state, digit_cnt}, {3'd0, 4'd0});
        digit(4'd1); digit(4'd2);
        do_reset();

        for (int n = 0; n < 6000; n++) begin
            if (m_state == 4 || $urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                r = $urandom_range(0, 99);
                if (r < 30) begin
                    if ($urandom_range(0, 1) == 1 && m_q.size() < DIGITS)
                        digit(4'(m_key[m_q.size()]));
                    else
                        digit(4'($urandom_range(0, 15)));
                end else if (r < 34) press_ok();
                else if (r < 37) cycle(0, 4'd0, 0, 1, 0);
                else if (r < 39) press_admin();
                else if (r < 42) cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                       1'($urandom_range(0, 1)));
                else idle(1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
